// File: rtl/sh7604_pkg.sv
// Shared types and byte-lane helpers for the SH7604 internal-bus master.
// Lanes are big-endian: address offset 0 is the most significant byte.
package sh7604_pkg;

    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_WORD = 2'd1, SZ_LONG = 2'd2, SZ_RSVD = 2'd3} size_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

    localparam logic [7:0] TMO_DEFAULT = 8'd255;

    function automatic logic misaligned(size_t sz, logic [1:0] ofs);
        case (sz)
            SZ_BYTE: misaligned = 1'b0;
            SZ_WORD: misaligned = ofs[0];
            SZ_LONG: misaligned = (ofs != 2'd0);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_ba(size_t sz, logic [1:0] ofs);
        case (sz)
            SZ_BYTE: lane_ba = 4'b1000 >> ofs;
            SZ_WORD: lane_ba = ofs[1] ? 4'b0011 : 4'b1100;
            default: lane_ba = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rep_data(size_t sz, logic [31:0] di);
        case (sz)
            SZ_BYTE: rep_data = {4{di[7:0]}};
            SZ_WORD: rep_data = {2{di[15:0]}};
            default: rep_data = di;
        endcase
    endfunction

    // Pick the addressed lane out of the bus word, right-aligned and zero-extended.
    function automatic logic [31:0] lane_rd(size_t sz, logic [1:0] ofs, logic [31:0] d);
        case (sz)
            SZ_BYTE: begin
                case (ofs)
                    2'd0:    lane_rd = {24'd0, d[31:24]};
                    2'd1:    lane_rd = {24'd0, d[23:16]};
                    2'd2:    lane_rd = {24'd0, d[15:8]};
                    default: lane_rd = {24'd0, d[7:0]};
                endcase
            end
            SZ_WORD: lane_rd = ofs[1] ? {16'd0, d[15:0]} : {16'd0, d[31:16]};
            default: lane_rd = d;
        endcase
    endfunction

endpackage

// File: rtl/sh7604_ibus_master.sv
// SH7604 core-to-internal-bus master: one access at a time, lane steering,
// wait-state counting with timeout, and unmapped-address detection.
module sh7604_ibus_master
    import sh7604_pkg::*;
#(
    parameter logic [7:0] TMO_MAX = TMO_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        CORE_REQ,
    input  logic [31:0] CORE_A,
    input  logic [31:0] CORE_DI,
    input  logic        CORE_WE,
    input  logic [1:0]  CORE_SZ,
    output logic [31:0] CORE_DO,
    output logic        CORE_ACK,
    output logic        CORE_BUSY,
    output logic        ADDR_ERR,
    output logic        BUS_ERR,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic [31:0] IBUS_DI,
    input  logic        IBUS_BUSY,
    input  logic        IBUS_ACT
);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    size_t      sz_q;
    logic [1:0] ofs_q;
    logic       req_ok, req_bad, done, tmo;
    size_t      sz_in;

    // The responder samples on CE_F; this side only acts on CE_R.
    logic unused_ce_f;
    assign unused_ce_f = CE_F;

    assign sz_in = size_t'(CORE_SZ);

    always_ff @(posedge CLK) begin
        if (RST)       state <= ST_IDLE;
        else if (CE_R) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_ok)      state_nxt = ST_ACCESS;
            ST_ACCESS: if (done || tmo) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_bad   = (state == ST_IDLE) && CORE_REQ &&  misaligned(sz_in, CORE_A[1:0]);
        req_ok    = (state == ST_IDLE) && CORE_REQ && !misaligned(sz_in, CORE_A[1:0]);
        done      = (state == ST_ACCESS) && !IBUS_BUSY;
        tmo       = (state == ST_ACCESS) && IBUS_BUSY && (wait_cnt == TMO_MAX);
        CORE_BUSY = (state == ST_ACCESS);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            IBUS_REQ <= 1'b0;
            IBUS_WE  <= 1'b0;
            IBUS_A   <= '0;
            IBUS_DO  <= '0;
            IBUS_BA  <= '0;
            CORE_DO  <= '0;
            CORE_ACK <= 1'b0;
            ADDR_ERR <= 1'b0;
            BUS_ERR  <= 1'b0;
            wait_cnt <= '0;
            sz_q     <= SZ_BYTE;
            ofs_q    <= '0;
        end else if (CE_R) begin
            CORE_ACK <= done || tmo;
            BUS_ERR  <= tmo || (done && !IBUS_ACT);
            ADDR_ERR <= req_bad;
            if (req_ok) begin
                IBUS_A   <= CORE_A;
                IBUS_WE  <= CORE_WE;
                IBUS_REQ <= 1'b1;
                IBUS_BA  <= lane_ba(sz_in, CORE_A[1:0]);
                IBUS_DO  <= rep_data(sz_in, CORE_DI);
                wait_cnt <= '0;
                sz_q     <= sz_in;
                ofs_q    <= CORE_A[1:0];
            end
            if (done || tmo)
                IBUS_REQ <= 1'b0;
            if ((state == ST_ACCESS) && IBUS_BUSY && !tmo)
                wait_cnt <= wait_cnt + 8'd1;
            // Timeouts and writes leave CORE_DO alone; unmapped reads return zero.
            if (done && !IBUS_WE)
                CORE_DO <= IBUS_ACT ? lane_rd(sz_q, ofs_q, IBUS_DI) : 32'd0;
        end
    end

endmodule

// File: tb/tb_sh7604_ibus_master.sv
// Directed bench for sh7604_ibus_master; one CE_R period is two CLKs (CE_R then CE_F).
module tb_sh7604_ibus_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CE_R = 1'b0, CE_F = 1'b0;
    logic        CORE_REQ = 1'b0;
    logic [31:0] CORE_A = '0, CORE_DI = '0;
    logic        CORE_WE = 1'b0;
    logic [1:0]  CORE_SZ = 2'd0;
    logic [31:0] CORE_DO;
    logic        CORE_ACK, CORE_BUSY, ADDR_ERR, BUS_ERR;
    logic [31:0] IBUS_A, IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE, IBUS_REQ;
    logic [31:0] IBUS_DI = '0;
    logic        IBUS_BUSY = 1'b0, IBUS_ACT = 1'b1;

    int checks = 0;
    int errors = 0;

    sh7604_ibus_master #(.TMO_MAX(8'd4)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F),
        .CORE_REQ(CORE_REQ), .CORE_A(CORE_A), .CORE_DI(CORE_DI), .CORE_WE(CORE_WE),
        .CORE_SZ(CORE_SZ), .CORE_DO(CORE_DO), .CORE_ACK(CORE_ACK), .CORE_BUSY(CORE_BUSY),
        .ADDR_ERR(ADDR_ERR), .BUS_ERR(BUS_ERR), .IBUS_A(IBUS_A), .IBUS_DO(IBUS_DO),
        .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_DI(IBUS_DI),
        .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT)
    );

    always #5 CLK = ~CLK;

    // One CE_R edge then one CE_F edge; outputs are sampled 1ns after the CE_F edge.
    task automatic step();
        CE_R = 1'b1;
        @(posedge CLK); #1;
        CE_R = 1'b0; CE_F = 1'b1;
        @(posedge CLK); #1;
        CE_F = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checks++; if (IBUS_REQ !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", IBUS_REQ); end
        checks++; if (CORE_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", CORE_BUSY); end
        checks++; if ({CORE_ACK, ADDR_ERR, BUS_ERR, IBUS_WE} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {CORE_ACK, ADDR_ERR, BUS_ERR, IBUS_WE}); end
        checks++; if ({IBUS_A, IBUS_DO, CORE_DO, IBUS_BA} !== 100'd0) begin errors++; $display("FAIL reset_data got %h/%h/%h/%b exp 0", IBUS_A, IBUS_DO, CORE_DO, IBUS_BA); end
    endtask

    task automatic test_byte_read();
        CORE_A = 32'hFFFF_FE81; CORE_SZ = 2'd0; CORE_WE = 1'b0; CORE_REQ = 1'b1;
        IBUS_DI = 32'h1122_3344; IBUS_BUSY = 1'b0; IBUS_ACT = 1'b1;
        step();
        CORE_REQ = 1'b0;
        checks++; if (IBUS_REQ !== 1'b1) begin errors++; $display("FAIL br_req got %b exp 1", IBUS_REQ); end
        checks++; if (IBUS_BA !== 4'b0100) begin errors++; $display("FAIL br_ba got %b exp 0100", IBUS_BA); end
        checks++; if (IBUS_A !== 32'hFFFF_FE81) begin errors++; $display("FAIL br_a got %h exp FFFFFE81", IBUS_A); end
        checks++; if (CORE_BUSY !== 1'b1 || CORE_ACK !== 1'b0) begin errors++; $display("FAIL br_busy got busy=%b ack=%b exp 1/0", CORE_BUSY, CORE_ACK); end
        step();
        checks++; if (CORE_ACK !== 1'b1 || BUS_ERR !== 1'b0) begin errors++; $display("FAIL br_ack got ack=%b berr=%b exp 1/0", CORE_ACK, BUS_ERR); end
        checks++; if (CORE_DO !== 32'h0000_0022) begin errors++; $display("FAIL br_do got %h exp 00000022", CORE_DO); end
        checks++; if (IBUS_REQ !== 1'b0 || CORE_BUSY !== 1'b0) begin errors++; $display("FAIL br_idle got req=%b busy=%b exp 0/0", IBUS_REQ, CORE_BUSY); end
        step();
        checks++; if (CORE_ACK !== 1'b0) begin errors++; $display("FAIL br_ack_pulse got %b exp 0", CORE_ACK); end
    endtask

    task automatic test_word_write();
        CORE_A = 32'hFFFF_FE82; CORE_SZ = 2'd1; CORE_WE = 1'b1; CORE_DI = 32'h0000_A55A; CORE_REQ = 1'b1;
        IBUS_DI = 32'hFFFF_FFFF;
        step();
        CORE_REQ = 1'b0;
        checks++; if (IBUS_DO !== 32'hA55A_A55A) begin errors++; $display("FAIL ww_do got %h exp A55AA55A", IBUS_DO); end
        checks++; if (IBUS_BA !== 4'b0011 || IBUS_WE !== 1'b1) begin errors++; $display("FAIL ww_ba_we got %b/%b exp 0011/1", IBUS_BA, IBUS_WE); end
        step();
        checks++; if (CORE_ACK !== 1'b1) begin errors++; $display("FAIL ww_ack got %b exp 1", CORE_ACK); end
        checks++; if (CORE_DO !== 32'h0000_0022) begin errors++; $display("FAIL ww_core_do got %h exp 00000022", CORE_DO); end
        step();
        checks++; if (CORE_ACK !== 1'b0) begin errors++; $display("FAIL ww_one_ack got %b exp 0", CORE_ACK); end
        CORE_WE = 1'b0;
    endtask

    task automatic test_addr_err();
        CORE_A = 32'h0000_0002; CORE_SZ = 2'd2; CORE_REQ = 1'b1;
        step();
        CORE_REQ = 1'b0;
        checks++; if (ADDR_ERR !== 1'b1) begin errors++; $display("FAIL ae_long got %b exp 1", ADDR_ERR); end
        checks++; if (IBUS_REQ !== 1'b0 || CORE_BUSY !== 1'b0) begin errors++; $display("FAIL ae_nobus got req=%b busy=%b exp 0/0", IBUS_REQ, CORE_BUSY); end
        step();
        checks++; if (ADDR_ERR !== 1'b0 || CORE_ACK !== 1'b0) begin errors++; $display("FAIL ae_pulse got aerr=%b ack=%b exp 0/0", ADDR_ERR, CORE_ACK); end
        CORE_A = 32'h0000_0001; CORE_SZ = 2'd1; CORE_REQ = 1'b1;
        step();
        CORE_REQ = 1'b0;
        checks++; if (ADDR_ERR !== 1'b1 || IBUS_REQ !== 1'b0) begin errors++; $display("FAIL ae_word got aerr=%b req=%b exp 1/0", ADDR_ERR, IBUS_REQ); end
        CORE_A = 32'h0000_0000; CORE_SZ = 2'd3; CORE_REQ = 1'b1;
        step();
        CORE_REQ = 1'b0;
        checks++; if (ADDR_ERR !== 1'b1 || IBUS_REQ !== 1'b0) begin errors++; $display("FAIL ae_sz3 got aerr=%b req=%b exp 1/0", ADDR_ERR, IBUS_REQ); end
        step();
    endtask

    task automatic test_wait_states();
        CORE_A = 32'h0000_0010; CORE_SZ = 2'd2; CORE_REQ = 1'b1;
        IBUS_BUSY = 1'b1; IBUS_DI = 32'hDEAD_BEEF;
        step();
        CORE_REQ = 1'b0;
        checks++; if (IBUS_BA !== 4'b1111) begin errors++; $display("FAIL ws_ba got %b exp 1111", IBUS_BA); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (CORE_ACK !== 1'b0 || IBUS_REQ !== 1'b1) begin errors++; $display("FAIL ws_wait%0d got ack=%b req=%b exp 0/1", i, CORE_ACK, IBUS_REQ); end
            checks++; if (IBUS_A !== 32'h0000_0010) begin errors++; $display("FAIL ws_hold%0d got %h exp 00000010", i, IBUS_A); end
        end
        IBUS_BUSY = 1'b0; IBUS_DI = 32'hCAFE_F00D;
        step();
        checks++; if (CORE_ACK !== 1'b1 || BUS_ERR !== 1'b0) begin errors++; $display("FAIL ws_ack got ack=%b berr=%b exp 1/0", CORE_ACK, BUS_ERR); end
        checks++; if (CORE_DO !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws_do got %h exp CAFEF00D", CORE_DO); end
        step();
    endtask

    task automatic test_timeout();
        CORE_A = 32'h0000_0020; CORE_SZ = 2'd2; CORE_REQ = 1'b1;
        IBUS_BUSY = 1'b1; IBUS_DI = 32'h0BAD_0BAD;
        step();
        CORE_REQ = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (CORE_ACK !== 1'b0 || BUS_ERR !== 1'b0) begin errors++; $display("FAIL to_sample%0d got ack=%b berr=%b exp 0/0", i, CORE_ACK, BUS_ERR); end
        end
        step();
        checks++; if (CORE_ACK !== 1'b1 || BUS_ERR !== 1'b1) begin errors++; $display("FAIL to_fire got ack=%b berr=%b exp 1/1", CORE_ACK, BUS_ERR); end
        checks++; if (IBUS_REQ !== 1'b0) begin errors++; $display("FAIL to_req got %b exp 0", IBUS_REQ); end
        checks++; if (CORE_DO !== 32'hCAFE_F00D) begin errors++; $display("FAIL to_do got %h exp CAFEF00D", CORE_DO); end
        IBUS_BUSY = 1'b0;
        step();
        checks++; if (CORE_ACK !== 1'b0 || BUS_ERR !== 1'b0) begin errors++; $display("FAIL to_pulse got ack=%b berr=%b exp 0/0", CORE_ACK, BUS_ERR); end
    endtask

    task automatic test_unmapped();
        CORE_A = 32'h0000_0003; CORE_SZ = 2'd0; CORE_REQ = 1'b1;
        IBUS_ACT = 1'b0; IBUS_DI = 32'hFFFF_FFFF;
        step();
        CORE_REQ = 1'b0;
        checks++; if (IBUS_BA !== 4'b0001) begin errors++; $display("FAIL um_ba got %b exp 0001", IBUS_BA); end
        step();
        checks++; if (CORE_ACK !== 1'b1 || BUS_ERR !== 1'b1) begin errors++; $display("FAIL um_flags got ack=%b berr=%b exp 1/1", CORE_ACK, BUS_ERR); end
        checks++; if (CORE_DO !== 32'h0) begin errors++; $display("FAIL um_do got %h exp 00000000", CORE_DO); end
        IBUS_ACT = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        CORE_A = 32'h0000_0002; CORE_SZ = 2'd1; CORE_WE = 1'b0; CORE_REQ = 1'b1;
        IBUS_DI = 32'h1122_3344;
        step();
        step();
        checks++; if (CORE_ACK !== 1'b1 || CORE_DO !== 32'h0000_3344) begin errors++; $display("FAIL b2b_first got ack=%b do=%h exp 1/00003344", CORE_ACK, CORE_DO); end
        checks++; if (IBUS_REQ !== 1'b0 || CORE_BUSY !== 1'b0) begin errors++; $display("FAIL b2b_gap got req=%b busy=%b exp 0/0", IBUS_REQ, CORE_BUSY); end
        step();
        CORE_REQ = 1'b0;
        checks++; if (IBUS_REQ !== 1'b1 || CORE_ACK !== 1'b0) begin errors++; $display("FAIL b2b_relaunch got req=%b ack=%b exp 1/0", IBUS_REQ, CORE_ACK); end
        CORE_A = 32'h0000_0000; IBUS_DI = 32'h5566_7788;
        step();
        checks++; if (CORE_ACK !== 1'b1 || CORE_DO !== 32'h0000_7788) begin errors++; $display("FAIL b2b_second got ack=%b do=%h exp 1/00007788", CORE_ACK, CORE_DO); end
        step();
    endtask

    task automatic test_reset_mid_access();
        CORE_A = 32'h0000_0040; CORE_SZ = 2'd2; CORE_REQ = 1'b1; IBUS_BUSY = 1'b1;
        step();
        CORE_REQ = 1'b0;
        checks++; if (IBUS_REQ !== 1'b1) begin errors++; $display("FAIL rm_launch got %b exp 1", IBUS_REQ); end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checks++; if (IBUS_REQ !== 1'b0 || CORE_BUSY !== 1'b0) begin errors++; $display("FAIL rm_abandon got req=%b busy=%b exp 0/0", IBUS_REQ, CORE_BUSY); end
        checks++; if (CORE_ACK !== 1'b0 || BUS_ERR !== 1'b0 || CORE_DO !== 32'h0 || IBUS_A !== 32'h0) begin errors++; $display("FAIL rm_clear got ack=%b berr=%b do=%h a=%h exp 0", CORE_ACK, BUS_ERR, CORE_DO, IBUS_A); end
        IBUS_BUSY = 1'b0;
        step();
        checks++; if (CORE_ACK !== 1'b0 || IBUS_REQ !== 1'b0) begin errors++; $display("FAIL rm_noack got ack=%b req=%b exp 0/0", CORE_ACK, IBUS_REQ); end
    endtask

    initial begin
        test_reset();
        test_byte_read();
        test_word_write();
        test_addr_err();
        test_wait_states();
        test_timeout();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sh7604_ibus_master.md
SH7604_IBUS_MASTER -- requirements
Module: SH7604_IBUS_MASTER

Interface
REQ-001 SHALL have parameter TMO_MAX, default 8'd255, meaning the maximum number of CE_R wait samples before a bus error.
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous to CLK and active-high.
REQ-004 SHALL have ports CE_R and CE_F, input, 1 bit each: rising-phase and falling-phase clock enables.
REQ-005 SHALL have port CORE_REQ, input, 1 bit: access request, sampled on CE_R.
REQ-006 SHALL have ports CORE_A (input, 32), CORE_DI (input, 32), CORE_WE (input, 1) and CORE_SZ (input, 2; 0=byte, 1=word, 2=long): address, right-aligned write data, write enable and access size.
REQ-007 SHALL have ports CORE_DO (output, 32), CORE_ACK (output, 1), CORE_BUSY (output, 1), ADDR_ERR (output, 1) and BUS_ERR (output, 1).
REQ-008 SHALL have bus ports IBUS_A (output, 32), IBUS_DO (output, 32), IBUS_BA (output, 4), IBUS_WE (output, 1) and IBUS_REQ (output, 1).
REQ-009 SHALL have bus ports IBUS_DI (input, 32), IBUS_BUSY (input, 1) and IBUS_ACT (input, 1).

Function
REQ-010 SHALL implement the states IDLE and ACCESS; all state, output and counter updates occur only on CLK edges with CE_R=1, except reset.
REQ-011 SHALL, in IDLE with CORE_REQ=1, raise ADDR_ERR for one CE_R period and stay IDLE with no bus cycle if the access is misaligned (word with A[0]=1; long with A[1:0]!=0) or CORE_SZ=3.
REQ-012 SHALL, for an aligned request in IDLE, register IBUS_A=CORE_A, IBUS_WE=CORE_WE and IBUS_REQ=1, clear the wait counter, and enter ACCESS.
REQ-013 SHALL map byte lanes big-endian: byte at offset n -> IBUS_BA bit (3-n) and data bits [31-8n:24-8n]; word at offset 0 -> BA=1100, at offset 2 -> BA=0011; long -> BA=1111.
REQ-014 SHALL drive IBUS_DO as CORE_DI replicated: byte [7:0] x4; word [15:0] x2; long unchanged.
REQ-015 SHALL, in ACCESS on each CE_R with IBUS_BUSY=0, complete the access: IBUS_REQ=0, CORE_ACK=1 for one CE_R period, return to IDLE.
REQ-016 SHALL, on a read completion, load CORE_DO with the addressed lane right-aligned and zero-extended; on a write completion, leave CORE_DO unchanged.
REQ-017 SHALL treat a completion with IBUS_ACT=0 as unmapped: CORE_DO=0 (reads), and CORE_ACK and BUS_ERR both pulsed.
REQ-018 SHALL, in ACCESS with IBUS_BUSY=1, increment the 8-bit wait counter; when the counter equals TMO_MAX, complete as in REQ-015 with BUS_ERR=1 and CORE_DO unchanged.
REQ-019 SHALL hold IBUS_A, IBUS_DO, IBUS_BA and IBUS_WE stable throughout ACCESS.
REQ-020 SHALL give a minimum latency of 1 CE_R period from IBUS_REQ rising to CORE_ACK, with responder data valid after the intervening CE_F.
REQ-021 SHALL assert CORE_BUSY=1 exactly while in ACCESS, and ignore CORE_REQ while in ACCESS.
REQ-022 SHALL let a CORE_REQ present in the same CE_R period as CORE_ACK start a new access only in the following CE_R period (no back-to-back launch).

Reset
REQ-023 SHALL, with RST=1 on any CLK edge regardless of CE_R/CE_F, enter IDLE and clear to 0: IBUS_REQ, IBUS_WE, IBUS_A, IBUS_DO, IBUS_BA, CORE_DO, CORE_ACK, ADDR_ERR, BUS_ERR and the wait counter.
REQ-024 SHALL, on reset during ACCESS, abandon the access with no CORE_ACK and no BUS_ERR.

Structure
REQ-025 SHALL place the size encoding typedef, the state typedef and the default timeout constant in SH7604_PKG.
REQ-026 SHALL place byte-lane and replication logic in package functions; no sub-module is required.

Verification
REQ-027 SHALL cover: byte read A=FFFFFE81, responder returns 0x11223344 with BUSY=0 -> BA=0100, CORE_DO=0x00000022, ACK after 1 CE_R.
REQ-028 SHALL cover: word write A=FFFFFE82, DI=0x0000A55A -> IBUS_DO=0xA55AA55A, BA=0011, WE=1, one ACK.
REQ-029 SHALL cover: long read A=00000002 -> ADDR_ERR pulse, IBUS_REQ stays 0, no ACK.
REQ-030 SHALL cover: BUSY held 1 for 3 CE_R, then 0 -> ACK on the 4th CE_R and data captured then.
REQ-031 SHALL cover: BUSY held 1 with TMO_MAX=4 -> BUS_ERR and ACK on the 5th sample, then IBUS_REQ=0.
REQ-032 SHALL cover: RST=1 mid-ACCESS with CE_R=0 -> IBUS_REQ=0 on the next CLK, no ACK.
